// File: rtl/dac_rx.sv
// Loopback monitor for the DAC serial pins: synchronizes sclk/cs_n/sin and rebuilds each word.
// Flags short or overrun frames and counts good frames per 1pps interval.
//
// state    | meaning
// ST_IDLE  | waiting for a cs_n falling edge with rx_ena high
// ST_SHIFT | inside a frame, shifting sin on each sclk rising edge
module dac_rx #(
   parameter int BITS  = 16,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rx_ena,
   input  logic             tsc_1pps,
   input  logic             dac_sclk,
   input  logic             dac_cs_n,
   input  logic             dac_sin,
   output logic [BITS-1:0]  rx_val,
   output logic             rx_valid,
   output logic             rx_err,
   output logic             rx_busy,
   output logic [CNT_W-1:0] rx_fps
);

   localparam int BC_W = $clog2(BITS + 2);
   localparam logic [BC_W-1:0]  BC_FULL = BC_W'(BITS);
   localparam logic [BC_W-1:0]  BC_SAT  = BC_W'(BITS + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

   // [0] and [1] form the synchronizer, [2] is the history flop
   logic [2:0] sclk_q;
   logic [2:0] cs_q;
   logic [1:0] sin_q;
   logic       sin_bit_q;

   logic sclk_rise_d, cs_fall_d, cs_rise_d;
   logic sclk_rise_q, cs_fall_q, cs_rise_q;

   state_t           state_q;
   logic [BC_W-1:0]  bit_cnt_q;
   logic [BITS-1:0]  shift_q;
   logic [BITS-1:0]  rx_val_q;
   logic             rx_valid_q;
   logic             rx_err_q;
   logic             rx_busy_q;
   logic [CNT_W-1:0] fcnt_q;
   logic [CNT_W-1:0] fcnt_inc_d;
   logic [CNT_W-1:0] rx_fps_q;

   assign sclk_rise_d = sclk_q[1] & ~sclk_q[2];
   assign cs_fall_d   = ~cs_q[1] & cs_q[2];
   assign cs_rise_d   = cs_q[1] & ~cs_q[2];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_q      <= 3'b111;
         cs_q        <= 3'b111;
         sin_q       <= 2'b11;
         sin_bit_q   <= 1'b1;
         sclk_rise_q <= 1'b0;
         cs_fall_q   <= 1'b0;
         cs_rise_q   <= 1'b0;
      end else begin
         sclk_q      <= {sclk_q[1:0], dac_sclk};
         cs_q        <= {cs_q[1:0], dac_cs_n};
         sin_q       <= {sin_q[0], dac_sin};
         // data is registered alongside the edge pulse so both stay aligned
         sin_bit_q   <= sin_q[1];
         sclk_rise_q <= sclk_rise_d;
         cs_fall_q   <= cs_fall_d;
         cs_rise_q   <= cs_rise_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         rx_val_q   <= '0;
         rx_valid_q <= 1'b0;
         rx_err_q   <= 1'b0;
         rx_busy_q  <= 1'b0;
      end else begin
         rx_valid_q <= 1'b0;
         rx_err_q   <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (rx_ena && cs_fall_q) begin
                  state_q   <= ST_SHIFT;
                  bit_cnt_q <= '0;
                  shift_q   <= '0;
                  rx_busy_q <= 1'b1;
               end
            end
            ST_SHIFT: begin
               if (!rx_ena) begin
                  state_q   <= ST_IDLE;
                  rx_busy_q <= 1'b0;
               end else if (cs_rise_q) begin
                  // a coincident sclk edge is dropped; judge on the count so far
                  state_q   <= ST_IDLE;
                  rx_busy_q <= 1'b0;
                  if (bit_cnt_q == BC_FULL) begin
                     rx_val_q   <= shift_q;
                     rx_valid_q <= 1'b1;
                  end else begin
                     rx_err_q <= 1'b1;
                  end
               end else if (sclk_rise_q) begin
                  shift_q <= {shift_q[BITS-2:0], sin_bit_q};
                  if (bit_cnt_q != BC_SAT) begin
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                  end
               end
            end
            default: begin
               state_q   <= ST_IDLE;
               rx_busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign fcnt_inc_d = (fcnt_q == CNT_MAX) ? fcnt_q : fcnt_q + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fcnt_q   <= '0;
         rx_fps_q <= '0;
      end else if (tsc_1pps) begin
         rx_fps_q <= rx_valid_q ? fcnt_inc_d : fcnt_q;
         fcnt_q   <= '0;
      end else if (rx_valid_q) begin
         fcnt_q <= fcnt_inc_d;
      end
   end

   assign rx_val   = rx_val_q;
   assign rx_valid = rx_valid_q;
   assign rx_err   = rx_err_q;
   assign rx_busy  = rx_busy_q;
   assign rx_fps   = rx_fps_q;

endmodule

// File: tb/tb_dac_rx.sv
// Bench for dac_rx: drives serial frames on the DAC pins and scoreboards every rx_valid/rx_err pulse.
`timescale 1ns/1ps
module tb_dac_rx;

   localparam int BITS  = 16;
   localparam int CNT_W = 16;

   logic             clk      = 1'b0;
   logic             rst_n    = 1'b0;
   logic             rx_ena   = 1'b1;
   logic             tsc_1pps = 1'b0;
   logic             dac_sclk = 1'b0;
   logic             dac_cs_n = 1'b1;
   logic             dac_sin  = 1'b0;
   logic [BITS-1:0]  rx_val;
   logic             rx_valid;
   logic             rx_err;
   logic             rx_busy;
   logic [CNT_W-1:0] rx_fps;

   typedef struct packed {
      logic            is_err;
      logic [BITS-1:0] val;
   } exp_t;

   exp_t            exp_q[$];
   exp_t            mon_e;
   logic [BITS-1:0] model_val = '0;
   int              n_tests = 0;
   int              n_fail  = 0;

   dac_rx #(.BITS(BITS), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rx_ena   (rx_ena),
      .tsc_1pps (tsc_1pps),
      .dac_sclk (dac_sclk),
      .dac_cs_n (dac_cs_n),
      .dac_sin  (dac_sin),
      .rx_val   (rx_val),
      .rx_valid (rx_valid),
      .rx_err   (rx_err),
      .rx_busy  (rx_busy),
      .rx_fps   (rx_fps)
   );

   always #2.5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   // every output pulse must match the oldest pending expectation
   always @(negedge clk) begin
      if (rst_n && (rx_valid || rx_err)) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_pulse valid=%0b err=%0b val=%h", rx_valid, rx_err, rx_val);
         end else begin
            mon_e = exp_q.pop_front();
            if ({rx_err, rx_valid, rx_val, rx_busy} !== {mon_e.is_err, ~mon_e.is_err, mon_e.val, 1'b0}) begin
               n_fail++;
               $display("FAIL pulse got err=%0b valid=%0b val=%h busy=%0b want err=%0b valid=%0b val=%h busy=0",
                        rx_err, rx_valid, rx_val, rx_busy, mon_e.is_err, ~mon_e.is_err, mon_e.val);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_good(input logic [BITS-1:0] v);
      exp_q.push_back({1'b0, v});
      model_val = v;
   endtask

   task automatic push_err();
      exp_q.push_back({1'b1, model_val});
   endtask

   task automatic cs_low();
      dac_cs_n = 1'b0;
      tick();
      tick();
   endtask

   task automatic send_bit(input logic b, input logic cs_with_rise);
      dac_sclk = 1'b0;
      dac_sin  = b;
      tick();
      tick();
      dac_sclk = 1'b1;
      if (cs_with_rise) dac_cs_n = 1'b1;
      tick();
      tick();
   endtask

   task automatic cs_high(input int gap);
      dac_sclk = 1'b0;
      tick();
      tick();
      dac_cs_n = 1'b1;
      repeat (gap) tick();
   endtask

   task automatic send_word(input logic [31:0] data, input int n);
      cs_low();
      for (int i = 0; i < n; i++) send_bit(data[n-1-i], 1'b0);
      cs_high(8);
   endtask

   task automatic tsc_pulse();
      tsc_1pps = 1'b1;
      tick();
      tsc_1pps = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_reset();
      repeat (3) tick();
      n_tests++;
      if ({rx_val, rx_valid, rx_err, rx_busy, rx_fps} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs got val=%h valid=%0b err=%0b busy=%0b fps=%0d want all 0",
                  rx_val, rx_valid, rx_err, rx_busy, rx_fps);
      end
      rst_n = 1'b1;
      repeat (6) tick();
      n_tests++;
      if ({rx_busy, rx_valid, rx_err} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_release got busy=%0b valid=%0b err=%0b want 0", rx_busy, rx_valid, rx_err);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] words [4];
      words[0] = 16'hAAAA; words[1] = 16'h5555; words[2] = 16'hA5A5; words[3] = 16'h5A5A;
      push_good(words[0]);
      dac_cs_n = 1'b0;
      tick(); tick(); tick();
      n_tests++;
      if (rx_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL busy_early got=%0b want=0", rx_busy);
      end
      tick();
      n_tests++;
      if (rx_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL busy_latency got=%0b want=1", rx_busy);
      end
      for (int i = 0; i < 16; i++) send_bit(words[0][15-i], 1'b0);
      cs_high(8);
      for (int w = 1; w < 4; w++) begin
         push_good(words[w]);
         send_word({16'h0, words[w]}, 16);
      end
      repeat (4) tick();
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL b2b_missing got pending=%0d want 0", exp_q.size());
      end
      n_tests++;
      if (rx_val !== 16'h5A5A) begin
         n_fail++;
         $display("FAIL b2b_last_val got=%h want=5a5a", rx_val);
      end
   endtask

   task automatic test_bad_frames();
      push_err();
      send_word(32'h0000_2ABC, 15);
      push_err();
      send_word(32'h0001_1234, 17);
      repeat (4) tick();
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL bad_missing got pending=%0d want 0", exp_q.size());
      end
      n_tests++;
      if (rx_val !== 16'h5A5A) begin
         n_fail++;
         $display("FAIL bad_val_hold got=%h want=5a5a", rx_val);
      end
   endtask

   task automatic test_ena_abort();
      cs_low();
      for (int i = 0; i < 8; i++) send_bit(1'b1, 1'b0);
      rx_ena = 1'b0;
      tick();
      tick();
      n_tests++;
      if (rx_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_busy got=%0b want=0", rx_busy);
      end
      for (int i = 0; i < 8; i++) send_bit(1'b1, 1'b0);
      cs_high(8);
      rx_ena = 1'b1;
      tick();
      // enable raised while cs_n is already low: that frame must be ignored
      rx_ena = 1'b0;
      cs_low();
      repeat (4) tick();
      rx_ena = 1'b1;
      for (int i = 0; i < 8; i++) send_bit(1'b0, 1'b0);
      n_tests++;
      if (rx_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL late_ena_busy got=%0b want=0", rx_busy);
      end
      for (int i = 0; i < 8; i++) send_bit(1'b1, 1'b0);
      cs_high(8);
      push_good(16'h0F0F);
      send_word(32'h0000_0F0F, 16);
      repeat (4) tick();
      n_tests++;
      if (exp_q.size() != 0 || rx_val !== 16'h0F0F) begin
         n_fail++;
         $display("FAIL abort_recover got val=%h pending=%0d want val=0f0f pending=0", rx_val, exp_q.size());
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] w;
      w = 16'hC3C3;
      cs_low();
      for (int i = 0; i < 8; i++) send_bit(w[15-i], 1'b0);
      rst_n    = 1'b0;
      dac_cs_n = 1'b1;
      dac_sclk = 1'b0;
      model_val = '0;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_tests++;
         if ({rx_val, rx_valid, rx_err, rx_busy, rx_fps} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs got val=%h valid=%0b err=%0b busy=%0b fps=%0d want all 0",
                     rx_val, rx_valid, rx_err, rx_busy, rx_fps);
         end
      end
      rst_n = 1'b1;
      repeat (6) tick();
      n_tests++;
      if (rx_busy !== 1'b0 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL reset_mid_spurious got busy=%0b pending=%0d want 0", rx_busy, exp_q.size());
      end
      push_good(w);
      send_word({16'h0, w}, 16);
      repeat (4) tick();
      n_tests++;
      if (rx_val !== 16'hC3C3 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL reset_mid_frame got val=%h pending=%0d want c3c3", rx_val, exp_q.size());
      end
   endtask

   task automatic test_fps();
      logic [15:0] w;
      tsc_pulse();
      n_tests++;
      if (rx_fps !== 16'd1) begin
         n_fail++;
         $display("FAIL fps_first got=%0d want=1", rx_fps);
      end
      for (int f = 0; f < 6; f++) begin
         w = 16'h1111 * 16'(f + 1);
         push_good(w);
         send_word({16'h0, w}, 16);
      end
      w = 16'hBEEF;
      push_good(w);
      cs_low();
      for (int i = 0; i < 16; i++) send_bit(w[15-i], 1'b0);
      dac_sclk = 1'b0;
      tick();
      tick();
      dac_cs_n = 1'b1;
      repeat (4) tick();
      tsc_1pps = 1'b1;
      n_tests++;
      if (rx_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL fps_coincide_valid got=%0b want=1", rx_valid);
      end
      tick();
      tsc_1pps = 1'b0;
      tick();
      tick();
      n_tests++;
      if (rx_fps !== 16'd7) begin
         n_fail++;
         $display("FAIL fps_seven got=%0d want=7", rx_fps);
      end
      repeat (8) tick();
      tsc_pulse();
      n_tests++;
      if (rx_fps !== 16'd0) begin
         n_fail++;
         $display("FAIL fps_zero got=%0d want=0", rx_fps);
      end
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL fps_missing got pending=%0d want 0", exp_q.size());
      end
   endtask

   task automatic test_coincident_edge();
      logic [15:0] w;
      w = 16'h9C36;
      push_err();
      cs_low();
      for (int i = 0; i < 15; i++) send_bit(w[15-i], 1'b0);
      send_bit(w[0], 1'b1);
      dac_sclk = 1'b0;
      repeat (8) tick();
      n_tests++;
      if (exp_q.size() != 0 || rx_val !== model_val) begin
         n_fail++;
         $display("FAIL coincident_edge got val=%h pending=%0d want val=%h pending=0",
                  rx_val, exp_q.size(), model_val);
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_bad_frames();
      test_ena_abort();
      test_reset_mid();
      test_fps();
      test_coincident_edge();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dac_rx.md
# dac_rx

Serial frame receiver for the DAC interface: oversamples `dac_sclk`, `dac_cs_n` and `dac_sin` in the system clock domain and reconstructs each 16-bit word. It flags malformed frames and reports the number of good frames per second, using the `tsc_1pps` time base. It sits beside the DAC driver as a loopback monitor on the DAC pins and checks that the value in the DAC matches the value commanded.

## Interface

**Parameters**
- `BITS`, default 16: data bits per frame.
- `CNT_W`, default 16: width of the frames-per-second counter.

**Ports**
- `clk` input 1: system clock, 200 MHz.
- `rst_n` input 1: reset, asynchronous, active-low.
- `rx_ena` input 1: receiver enable. Low forces IDLE and halts frame counting.
- `tsc_1pps` input 1: one-clk pulse per second, synchronous to `clk`.
- `dac_sclk` input 1: serial clock, asynchronous to `clk`.
- `dac_cs_n` input 1: frame select, active-low, asynchronous.
- `dac_sin` input 1: serial data, MSB first, asynchronous.
- `rx_val` output BITS: last good word.
- `rx_valid` output 1: one-clk pulse when `rx_val` updates.
- `rx_err` output 1: one-clk pulse on a bad frame.
- `rx_busy` output 1: high while in SHIFT.
- `rx_fps` output CNT_W: good frames counted in the previous 1pps interval.

## Operation

**Input conditioning and edge detection**
- Each serial input passes through a 2-flop synchronizer, then a third history flop for edge detection.
- `sclk_rise` = synced `dac_sclk` is 1 and its history flop is 0.
- `cs_fall` and `cs_rise` are defined the same way on synced `dac_cs_n`.

**State machine**
- IDLE:
  - On `cs_fall` with `rx_ena`=1: clear bit count and shift register, go to SHIFT.
  - `sclk_rise` in IDLE is ignored.
- SHIFT:
  - On `sclk_rise`: shift register ← {shift[BITS-2:0], synced `dac_sin`}.
  - Bit count increments, saturating at BITS+1. Shifting continues past BITS; only the last BITS bits are kept.
  - On `cs_rise`, if bit count == BITS: `rx_val` ← shift register and pulse `rx_valid`.
  - On `cs_rise`, if bit count ≠ BITS (short or overrun frame): pulse `rx_err`; `rx_val` holds.
  - Either way, go to IDLE.

**Frame counter**
- The internal counter increments on each `rx_valid` and saturates at 2^CNT_W−1.
- On `tsc_1pps`: `rx_fps` ← counter, and the counter restarts.
- If `rx_valid` and `tsc_1pps` coincide, that frame is included in the latched `rx_fps` and the counter restarts at 0.

**Boundary rules**
- `sclk_rise` and `cs_rise` in the same clk: the sclk edge is ignored. The frame is judged on the bit count before that edge.
- `sclk_rise` and `cs_fall` in the same clk: the sclk edge is ignored.
- `rx_ena` falls during SHIFT: go to IDLE immediately, with no `rx_valid` or `rx_err` for that frame. `rx_val` and `rx_fps` hold, and `tsc_1pps` still latches `rx_fps`.
- `rx_ena` low while `dac_cs_n` is low: no frame starts until a new `cs_fall` is seen with `rx_ena` high.
- Reset asserted mid-frame: everything clears asynchronously and the partial frame is discarded.

## Timing

- Reset values:
  - `rx_val`=0, `rx_valid`=0, `rx_err`=0, `rx_busy`=0, `rx_fps`=0, internal counter=0.
  - State=IDLE; synchronizer and history flops all 1 (idle-high `cs_n`, no false edge after reset).
- Input constraint: `dac_sclk` high and low phases ≥ 2 clk periods each (≥ 10 ns at 200 MHz).
- Input constraint: `dac_sin` stable ≥ 2 clk before and after each sclk rising edge.
- Input constraint: `dac_cs_n` high ≥ 2 clk between frames.
- Latency: a pin transition first sampled at clk edge k produces its edge-detect action at edge k+3.
- `rx_valid`/`rx_err` are high for exactly the clk cycle following edge k+3, where k is the first edge sampling `dac_cs_n`=1. `rx_val` changes on the same edge `rx_valid` rises.
- `rx_busy` rises 3 clk after `dac_cs_n` is first sampled low and falls together with the `rx_valid`/`rx_err` pulse.
- `rx_fps` updates on the clk edge after `tsc_1pps` is sampled high.

## Test plan

1. Four back-to-back frames 0xAAAA, 0x5555, 0xA5A5, 0x5A5A; sclk period 20 ns, `cs_n` high 40 ns between frames -> four `rx_valid` pulses, `rx_val` matching each word in order, no `rx_err`.
2. Frame with 15 sclk edges, then one with 17 edges (last 16 bits = 0x1234) -> `rx_err` once per frame, `rx_val` unchanged from its previous value, `rx_valid` never pulses.
3. `rx_ena` dropped after 8 bits of 0xFFFF, raised again, then a complete 0x0F0F frame -> no pulse for the aborted frame, `rx_valid` with `rx_val`=0x0F0F.
4. `rst_n` asserted for 5 clk mid-frame, then a complete 0xC3C3 frame -> all outputs 0 during reset, no spurious edge after release, `rx_val`=0xC3C3.
5. 7 good frames between two `tsc_1pps` pulses, the 7th `rx_valid` coincident with the second pulse -> `rx_fps`=7 after the second pulse. With 0 frames in the next second, `rx_fps`=0 after the third pulse.
6. Last sclk rising edge and `cs_n` rising edge driven on the same clk edge, 16 bits total -> `rx_err`, because the coincident sclk edge is not counted.
